// File: rtl/ram_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of an 8 KB synchronous RAM.
// Each access takes IDLE -> ISSUE -> CAPTURE, and the ack arrives in the next IDLE cycle.
module ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [12:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic        dma_ack,
  output logic [7:0]  dma_dout,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic       owner_dma;
  logic [3:0] starve_cnt;

  logic cpu_elig;
  logic dma_elig;
  logic grant_any;
  logic grant_dma;

  // A port in its ack cycle is masked so one request is never granted twice.
  always_comb begin
    cpu_elig  = cpu_req & ~cpu_ack;
    dma_elig  = dma_req & ~dma_ack;
    grant_any = cpu_elig | dma_elig;
    grant_dma = dma_elig & (~cpu_elig | (starve_cnt == LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_dma  <= 1'b0;
      starve_cnt <= 4'd0;
      ram_addr   <= 13'd0;
      ram_din    <= 8'd0;
      ram_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_dout   <= 8'd0;
      dma_dout   <= 8'd0;
      busy       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            owner_dma <= grant_dma;
            ram_addr  <= grant_dma ? dma_addr : cpu_addr;
            ram_din   <= grant_dma ? dma_din  : cpu_din;
            ram_we    <= grant_dma ? dma_we   : cpu_we;
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
            ram_we <= 1'b0;
          end
          // Counts CPU wins over a waiting DMA; any DMA win or DMA-quiet cycle clears it.
          if (!dma_req || grant_dma) begin
            starve_cnt <= 4'd0;
          end else if (grant_any && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= starve_cnt;
          end
        end
        ISSUE: begin
          state  <= CAPTURE;
          busy   <= 1'b1;
          ram_we <= 1'b0;
        end
        CAPTURE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ram_we <= 1'b0;
          if (owner_dma) begin
            dma_dout <= ram_dout;
            dma_ack  <= 1'b1;
          end else begin
            cpu_dout <= ram_dout;
            cpu_ack  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
